fp32_square_seq: RTL and testbench
==================================

Name: fp32_square_seq

Overview:
- Sequential IEEE-754 single-precision squarer: out = in * in, result always non-negative.
- It is the inverse-direction companion to the root-square datapath. It is used to check root-square outputs, by squaring them and comparing against the original operand, and as a stand-alone FPAU square op.
- The mantissa product is built by a 24-iteration shift-add loop, one partial product per cycle, so one multiplier array is reused instead of unrolled.
- Valid/ready handshake on both input and output.

Parameters:
- BIAS, 127, exponent bias.
- MANT_W, 24, significand width including hidden bit; also the iteration count.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  high only in IDLE.
- in  input  32  FP32 operand.
- out_valid  output  1  result present; held until accepted.
- out_ready  input  1  consumer accepts result.
- out  output  32  FP32 result.
- flags  output  3  {invalid, overflow, underflow}; valid with out_valid.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out=32'h0, flags=0, state=IDLE.
  - rst has priority over every other event, including mid-MUL and mid-DONE: any in-flight result is discarded.
  - Registers are cleared on the first rising edge with rst high.
- States: IDLE, MUL, RND, DONE.
- IDLE: on in_valid && in_ready, latch the operand and classify it.
  - NaN operand (exp=255, frac!=0) -> out = 32'h7FC00000 (quiet NaN), invalid=1, go to DONE.
  - Inf operand -> out = 32'h7F800000, go to DONE.
  - Zero or denormal operand (exp=0) -> out = 32'h00000000 (flush-to-zero), go to DONE.
  - Otherwise: mant = {1,frac}, exp_acc = 2*E - BIAS (10-bit signed), prod = 0, cnt = 0, go to MUL.
- MUL: each cycle, if mant[cnt] then prod += mant << cnt; cnt increments.
  - prod is 48 bits.
  - After the cnt = MANT_W-1 cycle, go to RND.
- RND: normalise and round, then go to DONE.
  - If prod[47]: significand = prod[46:24], guard = prod[23], sticky = |prod[22:0], exp_acc += 1.
  - Else: significand = prod[45:23], guard = prod[22], sticky = |prod[21:0].
  - Round to nearest even: increment when guard && (sticky || lsb).
  - A mantissa carry-out sets the fraction to 0 and increments exp_acc.
  - exp_acc >= 255 -> out = 32'h7F800000, overflow=1.
  - exp_acc <= 0 -> out = 32'h00000000, underflow=1 (no denormal outputs).
  - Otherwise out = {0, exp_acc[7:0], frac}.
- DONE: out_valid=1, and out and flags are stable while out_valid && !out_ready.
  - On out_ready: out_valid=0, flags cleared, go to IDLE.
  - in_ready rises the cycle after acceptance.
- Latency, counting from the accept edge to the edge where out_valid rises:
  - Normal operand: 1 + MANT_W + 1 = 26 cycles.
  - Special operand: 1 cycle.
- Throughput: one operation in flight. in_valid outside IDLE is ignored; the operand must be held by the producer.
- The sign bit of the input is ignored (x² ≥ 0), except that a NaN payload is not propagated.
- No simultaneous accept and output in the same cycle, because in_ready=0 whenever out_valid=1.

Decomposition:
- Shared package fp32_pkg:
  - constants QNAN=32'h7FC00000, PINF=32'h7F800000, PZERO=32'h0, BIAS.
  - field-extract helpers (sign, exp, frac).
  - state enum {IDLE, MUL, RND, DONE}.
- One natural sub-module: fp32_round_norm, purely combinational.
  - Input: 48-bit product and exp_acc.
  - Output: packed result plus overflow/underflow.
  - Reusable by the division and add_sub units.
- The FSM and the shift-add loop stay in the top module.

Test Plan:
- 2.0 (32'h40000000) -> out 32'h40800000 (4.0), flags 0.
  - out_valid rises exactly 26 cycles after accept.
- -1.5 (32'hBFC00000) -> 32'h40100000 (2.25); 3.0 (32'h40400000) -> 32'h41100000 (9.0), flags 0.
- 32'h7FC00000 (NaN) -> 32'h7FC00000, invalid=1, latency 1.
  - 32'h00000001 (denormal) -> 32'h00000000, latency 1, flags 0.
- 1e20 (32'h60AD78EC) -> 32'h7F800000 with overflow=1.
  - 2^-64 (32'h1F800000) -> 32'h00000000 with underflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - out, flags and out_valid stay stable; in_ready=0 throughout.
  - in_valid pulses during this window are ignored.
- Assert rst at MUL cycle 10 -> next cycle in_ready=1, out_valid=0, out=0.
  - A new operand 3.0 then yields 9.0 after 26 cycles.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: special-value encodings, field extractors and the
// sequencer state encoding used by the iterative FP32 arithmetic units.
package fp32_pkg;

    localparam int          BIAS  = 127;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    localparam logic [31:0] PINF  = 32'h7F80_0000;
    localparam logic [31:0] PZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] fp_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/fp32_square_seq_if.sv
// Operand/result handshake bundle for the FP32 squarer.
interface fp32_square_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [2:0]  flags;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out, flags
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out, flags
    );

endinterface

// File: rtl/fp32_round_norm.sv
// Normalises a 48-bit significand product, rounds to nearest-even and packs an
// FP32 result, flushing out-of-range exponents to +Inf or +0.
module fp32_round_norm
    import fp32_pkg::*;
(
    input  logic [47:0]       prod,
    input  logic signed [9:0] exp_acc,
    output logic [31:0]       res,
    output logic              overflow,
    output logic              underflow
);

    function automatic logic rne_inc(input logic guard, input logic sticky, input logic lsb);
        return guard & (sticky | lsb);
    endfunction

    logic [22:0]       sig;
    logic              guard;
    logic              sticky;
    logic [23:0]       sig_rnd;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_r;

    always_comb begin
        sig       = prod[45:23];
        guard     = prod[22];
        sticky    = |prod[21:0];
        exp_n     = exp_acc;
        if (prod[47]) begin
            sig    = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_n  = exp_acc + 10'sd1;
        end

        // Bit 23 of the rounded value is the carry out of the fraction.
        sig_rnd   = {1'b0, sig} + {23'd0, rne_inc(guard, sticky, sig[0])};
        exp_r     = sig_rnd[23] ? exp_n + 10'sd1 : exp_n;

        res       = {1'b0, exp_r[7:0], sig_rnd[22:0]};
        overflow  = 1'b0;
        underflow = 1'b0;
        if (exp_r >= 10'sd255) begin
            res      = PINF;
            overflow = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            res       = PZERO;
            underflow = 1'b1;
        end
    end

endmodule

// File: rtl/fp32_square_seq.sv
// Sequential FP32 squarer: one shift-add partial product per cycle, then a
// single normalise/round cycle; specials bypass the loop.
module fp32_square_seq #(
    parameter int BIAS   = fp32_pkg::BIAS,
    parameter int MANT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    fp32_square_seq_if.slave bus
);

    import fp32_pkg::*;

    localparam int CNT_W = $clog2(MANT_W);

    state_t              state;
    state_t              state_nx;
    logic [MANT_W-1:0]   mant;
    logic [2*MANT_W-1:0] prod;
    logic [CNT_W-1:0]    cnt;
    logic signed [9:0]   exp_acc;
    logic [31:0]         out_r;
    logic [2:0]          flags_r;
    logic                out_valid_r;
    logic                accept;
    logic                op_nan;
    logic                op_inf;
    logic                op_zero;
    logic [31:0]         rn_res;
    logic                rn_ovf;
    logic                rn_unf;

    assign accept  = (state == IDLE) && bus.in_valid;
    assign op_nan  = (fp_exp(bus.in) == 8'hFF) && (fp_frac(bus.in) != 23'd0);
    assign op_inf  = (fp_exp(bus.in) == 8'hFF) && (fp_frac(bus.in) == 23'd0);
    assign op_zero = (fp_exp(bus.in) == 8'h00);

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out       = out_r;
    assign bus.flags     = flags_r;

    fp32_round_norm u_round_norm (
        .prod      (prod),
        .exp_acc   (exp_acc),
        .res       (rn_res),
        .overflow  (rn_ovf),
        .underflow (rn_unf)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.in_valid) state_nx = (op_nan || op_inf || op_zero) ? DONE : MUL;
            MUL:  if (cnt == CNT_W'(MANT_W - 1)) state_nx = RND;
            RND:  state_nx = DONE;
            DONE: if (out_valid_r && bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control: state, iteration count and the result/flag holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_r <= 1'b0;
            out_r       <= PZERO;
            flags_r     <= 3'b000;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        if (op_nan) begin
                            out_r   <= QNAN;
                            flags_r <= 3'b100;
                        end else if (op_inf) begin
                            out_r   <= PINF;
                        end else if (op_zero) begin
                            out_r   <= PZERO;
                        end
                    end
                end
                MUL: cnt <= cnt + CNT_W'(1);
                RND: begin
                    out_r   <= rn_res;
                    flags_r <= {1'b0, rn_ovf, rn_unf};
                end
                DONE: begin
                    // out_valid is registered one cycle after entering DONE.
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        flags_r     <= 3'b000;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath: operand, exponent accumulator and shift-add product.
    always_ff @(posedge clk) begin
        if (accept) begin
            mant    <= {1'b1, fp_frac(bus.in)};
            exp_acc <= $signed({1'b0, fp_exp(bus.in), 1'b0}) - $signed(10'(BIAS));
            prod    <= '0;
        end else if (state == MUL) begin
            if (mant[cnt])
                prod <= prod + ({{MANT_W{1'b0}}, mant} << cnt);
        end
    end

endmodule

// File: tb/tb_fp32_square_seq.sv
// Scoreboard bench for fp32_square_seq: directed corner operands, backpressure,
// mid-operation reset and a batch of random operands.
module tb_fp32_square_seq;

    typedef struct {
        logic [31:0] out;
        logic [2:0]  flags;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    fp32_square_seq_if bus();

    fp32_square_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a);
        exp_t        r;
        logic [7:0]  e;
        logic [22:0] f;
        logic [47:0] p;
        logic [47:0] rem;
        logic [47:0] half;
        logic [24:0] sig;
        int          ex;
        int          sh;
        e       = a[30:23];
        f       = a[22:0];
        r.lat   = 1;
        r.flags = 3'b000;
        r.out   = 32'h0;
        if (e == 8'hFF && f != 23'd0) begin
            r.out   = 32'h7FC0_0000;
            r.flags = 3'b100;
        end else if (e == 8'hFF) begin
            r.out = 32'h7F80_0000;
        end else if (e != 8'h00) begin
            r.lat = 26;
            p     = {24'd0, 1'b1, f} * {24'd0, 1'b1, f};
            ex    = 2 * int'(e) - 127;
            sh    = p[47] ? 24 : 23;
            if (p[47]) ex++;
            sig   = 25'(p >> sh);
            rem   = p & ((48'd1 << sh) - 48'd1);
            half  = 48'd1 << (sh - 1);
            if (rem > half || (rem == half && sig[0])) sig++;
            if (sig[24]) begin
                sig = sig >> 1;
                ex++;
            end
            if (ex >= 255) begin
                r.out   = 32'h7F80_0000;
                r.flags = 3'b010;
            end else if (ex <= 0) begin
                r.out   = 32'h0;
                r.flags = 3'b001;
            end else begin
                r.out = {1'b0, 8'(ex), sig[22:0]};
            end
        end
        return r;
    endfunction

    task automatic accept_op(input logic [31:0] a);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in       = a;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 100), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input exp_t want, input int bp);
        exp_t        got;
        int          lat;
        logic [31:0] hold_out;
        logic [2:0]  hold_flags;
        sb.push_back(want);
        accept_op(a);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = sb.pop_front();
        chk("latency", 32'(lat), 32'(got.lat));
        chk("out", bus.out, got.out);
        chk("flags", 32'(bus.flags), 32'(got.flags));
        hold_out   = bus.out;
        hold_flags = bus.flags;
        for (int i = 0; i < bp; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in       = 32'h4040_0000;
            @(posedge clk);
            #1;
            chk("bp_out", bus.out, hold_out);
            chk("bp_flags", 32'(bus.flags), 32'(hold_flags));
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("post_valid", 32'(bus.out_valid), 32'd0);
        chk("post_flags", 32'(bus.flags), 32'd0);
        chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    function automatic exp_t mk(input logic [31:0] o, input logic [2:0] fl, input int lat);
        exp_t r;
        r.out   = o;
        r.flags = fl;
        r.lat   = lat;
        return r;
    endfunction

    initial begin
        logic [31:0] a;
        bus.in_valid  = 1'b0;
        bus.in        = 32'h0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out", bus.out, 32'h0);
        chk("rst_flags", 32'(bus.flags), 32'd0);
        rst = 1'b0;

        run_op(32'h4000_0000, mk(32'h4080_0000, 3'b000, 26), 0);
        run_op(32'hBFC0_0000, mk(32'h4010_0000, 3'b000, 26), 0);
        run_op(32'h4040_0000, mk(32'h4110_0000, 3'b000, 26), 0);
        run_op(32'h7FC0_0000, mk(32'h7FC0_0000, 3'b100, 1), 0);
        run_op(32'h0000_0001, mk(32'h0000_0000, 3'b000, 1), 0);
        run_op(32'hFF80_0000, mk(32'h7F80_0000, 3'b000, 1), 0);
        run_op(32'h60AD_78EC, mk(32'h7F80_0000, 3'b010, 26), 0);
        run_op(32'h1F80_0000, mk(32'h0000_0000, 3'b001, 26), 0);
        run_op(32'h3F80_0001, mk(32'h3F80_0002, 3'b000, 26), 10);

        // Reset in the middle of the multiply loop.
        accept_op(32'h4000_0000);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out", bus.out, 32'h0);
        run_op(32'h4040_0000, mk(32'h4110_0000, 3'b000, 26), 0);

        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            if (i < 7) a[30:23] = 8'($urandom_range(40, 215));
            run_op(a, model(a), (i == 3) ? 3 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
